// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract block:
// FSM state encoding, flag bit positions and the canonical quiet-NaN pattern.
package fp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_OUTPUT
    } state_t;

    // Bit positions inside flags = {invalid, overflow, inexact}
    localparam int FLAG_INEXACT  = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INVALID  = 2;
    localparam int FLAGS_W       = 3;

    // Widest word the NaN helper can build; callers slice the low bits.
    localparam int MAX_W = 64;

    // Canonical qNaN: sign 0, exponent all ones, mantissa MSB 1, rest 0.
    function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
        logic [MAX_W-1:0] exp_ones;
        exp_ones = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
        return exp_ones | (MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_addsub_param_if.sv
// Request/response bundle of the floating-point add/subtract unit.
interface fp_addsub_param_if
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic               start;
    logic               op;
    logic [W-1:0]       num1;
    logic [W-1:0]       num2;
    logic [W-1:0]       num_out;
    logic               done;
    logic               busy;
    logic [FLAGS_W-1:0] flags;

    modport master (
        output start, op, num1, num2,
        input  num_out, done, busy, flags
    );

    modport slave (
        input  start, op, num1, num2,
        output num_out, done, busy, flags
    );

endinterface

// File: rtl/fp_norm_shift.sv
// One normalisation step on the working sum: a right shift on carry-out,
// otherwise a single left shift while the hidden bit is clear and the
// exponent is above the subnormal floor. An all-zero sum is finished at once.
module fp_norm_shift
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+4:0]        mant_i,
    input  logic signed [EXP_W+1:0] exp_i,
    output logic [MAN_W+4:0]        mant_o,
    output logic signed [EXP_W+1:0] exp_o,
    output logic                    done_o
);
    // Carry sits at MX, hidden bit at MX-1, then fraction, guard, round, sticky.
    localparam int MX = MAN_W + 4;
    localparam logic signed [EXP_W+1:0] EXP_MIN = (EXP_W+2)'(1);

    // Single shift decision; done_o tells the FSM the sum is ready to round.
    always_comb begin
        mant_o = mant_i;
        exp_o  = exp_i;
        done_o = 1'b1;
        if (mant_i == '0) begin
            exp_o = EXP_MIN;
        end else if (mant_i[MX]) begin
            mant_o = {1'b0, mant_i[MX:2], mant_i[1] | mant_i[0]};
            exp_o  = exp_i + EXP_MIN;
        end else if (!mant_i[MX-1] && (exp_i > EXP_MIN)) begin
            mant_o = mant_i << 1;
            exp_o  = exp_i - EXP_MIN;
            done_o = mant_i[MX-2] || (exp_o == EXP_MIN);
        end
    end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754-style adder/subtractor with parameterised field widths.
// State advances on the falling clock edge; specials bypass the datapath.
module fp_addsub_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    fp_addsub_param_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 4;          // hidden | fraction | G | R | S
    localparam int EW    = EXP_W + 2;          // signed working exponent
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAN_W + 3);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);
    localparam logic [MAX_W-1:0]     QNAN_WIDE = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN = QNAN_WIDE[W-1:0];

    function automatic logic rne_up(input logic lsb, input logic guard, input logic rs);
        return guard & (rs | lsb);
    endfunction

    function automatic logic [W-1:0] inf_word(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    state_t               state_q, state_d;
    logic [W-1:0]         num_out_q, num_out_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    logic [W-1:0]         n1_q, n1_d, n2_q, n2_d;
    logic                 op_q, op_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic signed [EW-1:0] exp_q, exp_d, diff_q, diff_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d;
    logic [MW:0]          sum_q, sum_d;
    logic                 rsign_q, rsign_d;

    // Operand fields; num2 carries its effective sign (sign XOR op).
    logic                 s1, s2;
    logic [EXP_W-1:0]     e1f, e2f;
    logic [MAN_W-1:0]     f1, f2;
    logic                 nan1, nan2, inf1, inf2;
    logic signed [EW-1:0] e1, e2;
    logic [MW-1:0]        m1, m2;

    assign {s1, e1f, f1} = n1_q;
    assign s2   = n2_q[W-1] ^ op_q;
    assign e2f  = n2_q[W-2:MAN_W];
    assign f2   = n2_q[MAN_W-1:0];
    assign nan1 = (&e1f) & (|f1);
    assign nan2 = (&e2f) & (|f2);
    assign inf1 = (&e1f) & ~(|f1);
    assign inf2 = (&e2f) & ~(|f2);
    assign e1   = (|e1f) ? $signed({2'b00, e1f}) : EXP_ONE;
    assign e2   = (|e2f) ? $signed({2'b00, e2f}) : EXP_ONE;
    assign m1   = {|e1f, f1, 3'b000};
    assign m2   = {|e2f, f2, 3'b000};

    // Round-to-nearest-even on the normalised sum.
    logic                 inexact, rnd_up, hid_rnd;
    logic [MAN_W+1:0]     man_rnd;
    logic [MAN_W-1:0]     frac_rnd;
    logic signed [EW-1:0] exp_rnd;
    logic [EXP_W-1:0]     exp_fld;

    assign inexact  = |sum_q[2:0];
    assign rnd_up   = rne_up(sum_q[3], sum_q[2], sum_q[1] | sum_q[0]);
    assign man_rnd  = {1'b0, sum_q[MW-1:3]} + (MAN_W+2)'(rnd_up);
    assign hid_rnd  = man_rnd[MAN_W+1] | man_rnd[MAN_W];
    assign frac_rnd = man_rnd[MAN_W+1] ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];
    assign exp_rnd  = man_rnd[MAN_W+1] ? (exp_q + EXP_ONE) : exp_q;
    assign exp_fld  = hid_rnd ? exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}};

    logic [MW:0]          norm_mant;
    logic signed [EW-1:0] norm_exp;
    logic                 norm_done;

    fp_norm_shift #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm (
        .mant_i (sum_q),
        .exp_i  (exp_q),
        .mant_o (norm_mant),
        .exp_o  (norm_exp),
        .done_o (norm_done)
    );

    // Next-state, result and datapath updates for each FSM phase.
    always_comb begin
        state_d   = state_q;
        num_out_d = num_out_q;
        flags_d   = flags_q;
        n1_d      = n1_q;
        n2_d      = n2_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        exp_d     = exp_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        sum_d     = sum_q;
        rsign_d   = rsign_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n1_d    = bus.num1;
                    n2_d    = bus.num2;
                    op_d    = bus.op;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                cnt_d = '0;
                if (nan1 | nan2 | (inf1 & inf2 & (s1 != s2))) begin
                    num_out_d              = QNAN;
                    flags_d                = '0;
                    flags_d[FLAG_INVALID]  = 1'b1;
                    state_d                = S_OUTPUT;
                end else if (inf1) begin
                    num_out_d = inf_word(s1);
                    flags_d   = '0;
                    state_d   = S_OUTPUT;
                end else if (inf2) begin
                    num_out_d = inf_word(s2);
                    flags_d   = '0;
                    state_d   = S_OUTPUT;
                end else if (e2 > e1) begin
                    exp_d   = e2;
                    diff_d  = e2 - e1;
                    sa_d    = s2;
                    ma_d    = m2;
                    sb_d    = s1;
                    mb_d    = m1;
                    state_d = S_ALIGN;
                end else begin
                    exp_d   = e1;
                    diff_d  = e1 - e2;
                    sa_d    = s1;
                    ma_d    = m1;
                    sb_d    = s2;
                    mb_d    = m2;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (diff_q == '0) begin
                    state_d = S_ADD;
                end else if (cnt_q == CNT_MAX) begin
                    // Everything has already fallen into sticky; finish in one go.
                    mb_d    = {{(MW-1){1'b0}}, |mb_q};
                    diff_d  = '0;
                    state_d = S_ADD;
                end else begin
                    mb_d   = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                    diff_d = diff_q - EXP_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (diff_q == EXP_ONE) begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                if (sa_q == sb_q) begin
                    sum_d   = {1'b0, ma_q} + {1'b0, mb_q};
                    rsign_d = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum_d   = {1'b0, ma_q} - {1'b0, mb_q};
                    rsign_d = (ma_q == mb_q) ? 1'b0 : sa_q;
                end else begin
                    sum_d   = {1'b0, mb_q} - {1'b0, ma_q};
                    rsign_d = sb_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                sum_d = norm_mant;
                exp_d = norm_exp;
                if (norm_done) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                flags_d = '0;
                if (exp_rnd >= EXP_INF) begin
                    num_out_d              = inf_word(rsign_q);
                    flags_d[FLAG_OVERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]  = 1'b1;
                end else begin
                    num_out_d             = {rsign_q, exp_fld, frac_rnd};
                    flags_d[FLAG_INEXACT] = inexact;
                end
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and visible results; reset clears them immediately.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_out_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            num_out_q <= num_out_d;
            flags_q   <= flags_d;
        end
    end

    // Working datapath registers; always loaded before use, so no reset.
    always_ff @(negedge clk) begin
        n1_q    <= n1_d;
        n2_q    <= n2_d;
        op_q    <= op_d;
        sa_q    <= sa_d;
        sb_q    <= sb_d;
        exp_q   <= exp_d;
        diff_q  <= diff_d;
        cnt_q   <= cnt_d;
        ma_q    <= ma_d;
        mb_q    <= mb_d;
        sum_q   <= sum_d;
        rsign_q <= rsign_d;
    end

    assign bus.done    = (state_q == S_OUTPUT);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.num_out = num_out_q;
    assign bus.flags   = flags_q;

endmodule

// File: doc/fp_addsub_param.md
FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width (>=4); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the falling edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = num1+num2, 1 = num1-num2; captured with start.
REQ-007 SHALL have port num1, num2  input  W  IEEE-754-style operands (sign|exp|man), captured with start.
REQ-008 SHALL have port num_out  output  W  result; held stable until the next done.
REQ-009 SHALL have port done  output  1  one-cycle pulse, num_out/flags valid in the same cycle.
REQ-010 SHALL have port busy  output  1  high from the cycle after accepted start through the done cycle.
REQ-011 SHALL have port flags  output  3  {invalid, overflow, inexact}; updated with done.

Function
REQ-012 SHALL use bias = 2^(EXP_W-1)-1; effective sign of num2 = num2.sign XOR op.
REQ-013 SHALL run FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUTPUT -> IDLE; specials go UNPACK -> OUTPUT.
REQ-014 UNPACK SHALL treat exp=0 as zero/subnormal (hidden bit 0, exponent 1-bias); otherwise hidden bit 1.
REQ-015 Specials SHALL resolve in UNPACK: any NaN input or inf-inf of opposite effective sign -> canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0), invalid=1; a single inf -> that inf with its effective sign.
REQ-016 ALIGN SHALL shift the smaller-exponent mantissa right one bit per cycle, extended with guard, round and sticky bits (sticky = OR of all bits shifted past it); once the shift count reaches MAN_W+3 the remaining difference collapses in one cycle to mantissa 0, sticky = OR of the original.
REQ-017 ADD SHALL add magnitudes on equal effective signs, else subtract the smaller from the larger, result sign = sign of larger; an exact zero difference SHALL yield +0, and (-0)+(-0) SHALL yield -0.
REQ-018 NORM SHALL first right-shift by one on carry-out (exp+1, OR the shifted-out bit into sticky), then left-shift one bit per cycle while hidden bit = 0 and exp > 1-bias.
REQ-019 ROUND SHALL round to nearest, ties to even; a mantissa carry SHALL renormalise with exp+1; inexact = guard|round|sticky before rounding.
REQ-020 Result exp >= 2^EXP_W-1-bias after rounding SHALL give inf with the result sign, overflow=1, inexact=1.
REQ-021 A result left with hidden bit 0 at exp 1-bias SHALL be encoded as subnormal (exp field 0).
REQ-022 Worst-case latency start -> done SHALL not exceed 2*MAN_W+12 cycles; specials SHALL take exactly 3 cycles.
REQ-023 start while busy SHALL be ignored with no effect on the operation in flight.
REQ-024 done SHALL be low in all cycles except the OUTPUT cycle; back-to-back start in the cycle after done SHALL be accepted.

Reset
REQ-025 rst SHALL immediately force IDLE, done=0, busy=0, num_out=0, flags=0, including mid-operation; no partial result SHALL be emitted afterwards.
REQ-026 Datapath working registers need no reset value.

Structure
REQ-027 State encoding, the flag bit indices and a canonical-qNaN construction function SHALL live in shared package fp_pkg.
REQ-028 The leading-zero/normalise logic SHALL be a single sub-module fp_norm_shift; everything else stays in fp_addsub_param.

Verification (default EXP_W=8, MAN_W=23)
REQ-029 op=0, 0x3F800000 + 0x40000000 -> num_out 0x40400000, flags 000.
REQ-030 op=1, 0x3F800000 - 0x3F800000 -> 0x00000000, flags 000.
REQ-031 op=0, 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 100, done 3 cycles after start.
REQ-032 op=0, 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 011.
REQ-033 op=0, 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, flags 001; 0x00000001 + 0x00000001 -> 0x00000002, flags 000.
REQ-034 rst pulsed during ALIGN of 0x3F800000 + 0x33800000 -> outputs zero at once, no done; a following start of 1.0+2.0 -> 0x40400000.
